ras_driver: RTL and testbench
=============================

Name: ras_driver

Overview:
- Front end of the return-address-stack interface. Classifies the decoded RV32 instruction stream into push, pop and branch-checkpoint commands.
- Turns branch-resolution events into close_valid / close_invalid commands.
- Throttles fetch so the stack's branch checkpoint FIFO never overflows.
- Enforces the stack's timing rule: close_valid is never issued on two consecutive cycles.
- Sits between decode / branch-unit and the return address stack.

Parameters:
- WIDTH, 32, address / instruction-pointer width.
- MAX_BRANCHES, 128, checkpoint FIFO depth of the attached stack. Up to MAX_BRANCHES+1 unresolved branches are allowed.
- PEND_W, 8, width of the pending-valid-close counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- inst_valid  in  1  decoded instruction offered.
- inst_ready  out  1  instruction accepted when inst_valid && inst_ready.
- inst  in  32  instruction word.
- inst_pc  in  WIDTH  instruction address.
- resolve_valid  in  1  one conditional branch resolved (oldest first).
- resolve_mispredict  in  1  qualifies resolve_valid; resolution was a mispredict.
- ras_push  out  1  push command.
- ras_pop  out  1  pop command.
- ras_branch  out  1  open checkpoint.
- ras_close_valid  out  1  retire oldest checkpoint.
- ras_close_invalid  out  1  roll back all checkpoints.
- ras_din  out  WIDTH  return address to push.
- outstanding  out  $clog2(MAX_BRANCHES+2)  unresolved branch count.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset==0 at posedge) clears every register.
  - All ras_* outputs are 0, ras_din=0, outstanding=0, pending=0, err=0.
  - inst_ready is 0 while reset is low.
- Link registers are x1 and x5. Field extraction:
  - opcode=inst[6:0], rd=inst[11:7], rs1=inst[19:15].
  - JAL=1101111, JALR=1100111, BRANCH=1100011.
- Classification of an accepted instruction:
  - JAL with rd link: push.
  - JALR, rd link, rs1 not link: push.
  - JALR, rd not link, rs1 link: pop.
  - JALR, both link, rd!=rs1: pop and push in the same cycle.
  - JALR, both link, rd==rs1: push only.
  - BRANCH: branch.
  - Anything else: no command.
- Command latency: all ras_* outputs are registered.
  - A command appears exactly 1 cycle after acceptance and is a 1-cycle pulse.
  - ras_din = inst_pc + 4 (mod 2^WIDTH), registered alongside ras_push. It holds its value when no push is issued.
- inst_ready = reset && !(resolve_valid && resolve_mispredict) && (outstanding_n < MAX_BRANCHES+1).
  - outstanding_n is the count after this cycle's closes are applied.
  - Non-branch instructions are blocked too while full (in-order front end).
- Outstanding counter:
  - +1 per accepted BRANCH.
  - -1 per ras_close_valid issued.
  - Forced to 0 on mispredict.
- Pending counter: increments on resolve_valid && !resolve_mispredict. It saturates at 2^PEND_W-1, setting err.
- Close issue rule:
  - If pending>0, outstanding>0, and ras_close_valid was 0 last cycle, assert ras_close_valid next cycle and decrement both counters.
  - Otherwise wait. The result is at most one close every other cycle.
- Simultaneous new branch and close: both counters are updated in the same cycle (net 0 on outstanding). ras_branch and ras_close_valid may assert together.
- Mispredict (resolve_valid && resolve_mispredict):
  - Next cycle: ras_close_invalid=1; ras_push, ras_pop, ras_branch, ras_close_valid=0.
  - pending and outstanding are cleared.
  - No instruction is accepted in the mispredict cycle.
- Resolution with nothing to resolve: resolve_valid while outstanding + (accepted branch this cycle) <= pending sets err. err stays set until reset.
- Reset mid-operation drops all pending closes and issues no close_invalid.

Test Plan:
- Push/pop basics: JAL x1 at pc 0x100, then JALR x0,0(x1) -> ras_push=1 with ras_din=0x104 in cycle +1; ras_pop=1 one cycle after the JALR.
- Coroutine swap: JALR x5,0(x1) at pc 0x200 -> ras_pop=1 and ras_push=1 in the same cycle, ras_din=0x204. JALR x1,0(x1) -> push only.
- Back-to-back closes: open 3 branches, then 3 consecutive correct resolutions -> ras_close_valid pulses on cycles t+1, t+3, t+5; outstanding ends at 0.
- Full throttling: issue 129 branches with no resolution -> inst_ready drops after the 129th. One correct resolution -> ready returns the cycle ras_close_valid issues.
- Mispredict flush: 5 outstanding, 2 pending, then mispredict with a JAL offered -> JAL not accepted; ras_close_invalid=1 next cycle; outstanding=0; no close_valid afterwards.
- Error and reset: resolve_valid with outstanding=0 -> err=1 and stays set. Pull reset low -> all outputs 0 and err=0 next cycle.

Source files
------------

// File: rtl/ras_driver.sv
// Return-address-stack front end: decodes RV32 calls and returns into push/pop, opens branch
// checkpoints, converts branch resolutions into close commands and throttles fetch when the checkpoint FIFO is full.
module ras_driver #(
  parameter int WIDTH        = 32,
  parameter int MAX_BRANCHES = 128,
  parameter int PEND_W       = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                inst_valid,
  output logic                                inst_ready,
  input  logic [31:0]                         inst,
  input  logic [WIDTH-1:0]                    inst_pc,
  input  logic                                resolve_valid,
  input  logic                                resolve_mispredict,
  output logic                                ras_push,
  output logic                                ras_pop,
  output logic                                ras_branch,
  output logic                                ras_close_valid,
  output logic                                ras_close_invalid,
  output logic [WIDTH-1:0]                    ras_din,
  output logic [$clog2(MAX_BRANCHES+2)-1:0]   outstanding,
  output logic                                err
);
  localparam int OUT_W = $clog2(MAX_BRANCHES + 2);
  localparam int CMP_W = ((OUT_W > PEND_W) ? OUT_W : PEND_W) + 1;
  localparam logic [OUT_W-1:0]  FULL_CNT = OUT_W'(MAX_BRANCHES + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic                push_q, push_d, pop_q, pop_d, branch_q, branch_d;
  logic                close_valid_q, close_valid_d, close_invalid_q, close_invalid_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    din_q, din_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d, outstanding_n;
  logic [PEND_W-1:0]   pending_q, pending_d;

  logic                mispredict, close_fire, accept, pend_inc, sat_hit, over_resolve;
  logic                rd_link, rs1_link, is_jal, is_jalr, is_branch;
  logic [4:0]          rd, rs1;
  logic [PEND_W:0]     pend_res;
  logic                unused_inst_bits;

  assign unused_inst_bits = ^{inst[31:20], inst[14:12]};

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Returns {saturation_hit, next_pending}; a simultaneous increment and decrement cancel out.
  function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] p,
                                                input logic inc, input logic dec);
    if (inc && !dec)
      return (p == PEND_MAX) ? {1'b1, p} : {1'b0, p + 1'b1};
    else if (dec && !inc)
      return {1'b0, p - 1'b1};
    else
      return {1'b0, p};
  endfunction

  always_comb begin
    rd        = inst[11:7];
    rs1       = inst[19:15];
    rd_link   = is_link(rd);
    rs1_link  = is_link(rs1);
    is_jal    = (inst[6:0] == OP_JAL);
    is_jalr   = (inst[6:0] == OP_JALR);
    is_branch = (inst[6:0] == OP_BRANCH);

    mispredict    = resolve_valid && resolve_mispredict;
    pend_inc      = resolve_valid && !resolve_mispredict;
    close_fire    = (pending_q != '0) && (outstanding_q != '0) && !close_valid_q && !mispredict;
    outstanding_n = outstanding_q - OUT_W'(close_fire);
    inst_ready    = reset && !mispredict && (outstanding_n < FULL_CNT);
    accept        = inst_valid && inst_ready;

    // A resolution needs at least one unresolved branch, counting one accepted this cycle.
    over_resolve  = resolve_valid &&
                    ((CMP_W'(outstanding_q) + CMP_W'(accept && is_branch)) <= CMP_W'(pending_q));
    pend_res      = pend_next(pending_q, pend_inc, close_fire);
    sat_hit       = pend_res[PEND_W];

    push_d          = 1'b0;
    pop_d           = 1'b0;
    branch_d        = 1'b0;
    close_valid_d   = 1'b0;
    close_invalid_d = 1'b0;
    din_d           = din_q;
    outstanding_d   = outstanding_n;
    pending_d       = pend_res[PEND_W-1:0];
    err_d           = err_q || over_resolve || sat_hit;

    if (mispredict) begin
      close_invalid_d = 1'b1;
      outstanding_d   = '0;
      pending_d       = '0;
    end else begin
      close_valid_d = close_fire;
      if (accept) begin
        push_d   = (is_jal && rd_link) || (is_jalr && rd_link);
        pop_d    = is_jalr && rs1_link && (!rd_link || (rd != rs1));
        branch_d = is_branch;
        if (is_branch)
          outstanding_d = outstanding_n + 1'b1;
        if (push_d)
          din_d = inst_pc + WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      push_q          <= 1'b0;
      pop_q           <= 1'b0;
      branch_q        <= 1'b0;
      close_valid_q   <= 1'b0;
      close_invalid_q <= 1'b0;
      din_q           <= '0;
      outstanding_q   <= '0;
      pending_q       <= '0;
      err_q           <= 1'b0;
    end else begin
      push_q          <= push_d;
      pop_q           <= pop_d;
      branch_q        <= branch_d;
      close_valid_q   <= close_valid_d;
      close_invalid_q <= close_invalid_d;
      din_q           <= din_d;
      outstanding_q   <= outstanding_d;
      pending_q       <= pending_d;
      err_q           <= err_d;
    end
  end

  assign ras_push          = push_q;
  assign ras_pop           = pop_q;
  assign ras_branch        = branch_q;
  assign ras_close_valid   = close_valid_q;
  assign ras_close_invalid = close_invalid_q;
  assign ras_din           = din_q;
  assign outstanding       = outstanding_q;
  assign err               = err_q;
endmodule

// File: tb/tb_ras_driver.sv
// Directed bench for ras_driver: decode table plus close pacing, throttling, flush and error sequences.
module tb_ras_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        resolve_valid, resolve_mispredict;
  logic        ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
  logic [31:0] ras_din;
  logic [7:0]  outstanding;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011, ADDI = 7'b0010011;

  ras_driver dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .resolve_valid(resolve_valid),
    .resolve_mispredict(resolve_mispredict), .ras_push(ras_push), .ras_pop(ras_pop),
    .ras_branch(ras_branch), .ras_close_valid(ras_close_valid),
    .ras_close_invalid(ras_close_invalid), .ras_din(ras_din),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        push, pop, br;
    logic [31:0] din;
    logic [7:0]  outst;
  } vec_t;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic push, input logic pop, input logic br,
                          input logic cv, input logic ci, input logic [31:0] din,
                          input logic [7:0] outst, input logic e);
    chk({nm, ".push"}, ras_push, push);
    chk({nm, ".pop"}, ras_pop, pop);
    chk({nm, ".branch"}, ras_branch, br);
    chk({nm, ".close_valid"}, ras_close_valid, cv);
    chk({nm, ".close_invalid"}, ras_close_invalid, ci);
    chk({nm, ".din"}, ras_din, din);
    chk({nm, ".outstanding"}, outstanding, outst);
    chk({nm, ".err"}, err, e);
  endtask

  // Called at posedge+1; drives one cycle, samples ready mid-cycle, returns at next posedge+1.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rv, input logic rm, output logic rdy);
    inst_valid = v; inst = ins; inst_pc = pc; resolve_valid = rv; resolve_mispredict = rm;
    #1 rdy = inst_ready;
    @(posedge clk); #1;
    inst_valid = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b0; inst_valid = 1'b1; inst = enc(JAL, 5'd1, 5'd0); inst_pc = 32'h40;
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    #1 chk({nm, ".ready_in_reset"}, inst_ready, 1'b0);
    @(posedge clk); #1;
    chk_outs(nm, 0, 0, 0, 0, 0, 32'h0, 8'd0, 0);
    reset = 1'b1; inst_valid = 1'b0;
  endtask

  vec_t tbl[12];
  logic rdy;
  logic cv_seen[7];
  int   cv_count;

  initial begin
    reset = 1'b0; inst_valid = 1'b0; inst = '0; inst_pc = '0;
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    @(posedge clk); #1;

    tbl[0]  = '{1'b1, enc(JAL,  5'd1, 5'd0), 32'h100,      1'b1, 1'b0, 1'b0, 32'h104, 8'd0};
    tbl[1]  = '{1'b1, enc(JALR, 5'd0, 5'd1), 32'h300,      1'b0, 1'b1, 1'b0, 32'h104, 8'd0};
    tbl[2]  = '{1'b1, enc(JALR, 5'd5, 5'd1), 32'h200,      1'b1, 1'b1, 1'b0, 32'h204, 8'd0};
    tbl[3]  = '{1'b1, enc(JALR, 5'd1, 5'd1), 32'h208,      1'b1, 1'b0, 1'b0, 32'h20c, 8'd0};
    tbl[4]  = '{1'b1, enc(JALR, 5'd1, 5'd6), 32'h400,      1'b1, 1'b0, 1'b0, 32'h404, 8'd0};
    tbl[5]  = '{1'b1, enc(JALR, 5'd0, 5'd6), 32'h410,      1'b0, 1'b0, 1'b0, 32'h404, 8'd0};
    tbl[6]  = '{1'b1, enc(JAL,  5'd0, 5'd0), 32'h420,      1'b0, 1'b0, 1'b0, 32'h404, 8'd0};
    tbl[7]  = '{1'b1, enc(JAL,  5'd5, 5'd0), 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 32'h0,   8'd0};
    tbl[8]  = '{1'b1, enc(ADDI, 5'd1, 5'd5), 32'h430,      1'b0, 1'b0, 1'b0, 32'h0,   8'd0};
    tbl[9]  = '{1'b1, enc(BR,   5'd1, 5'd1), 32'h500,      1'b0, 1'b0, 1'b1, 32'h0,   8'd1};
    tbl[10] = '{1'b1, enc(JALR, 5'd5, 5'd5), 32'h600,      1'b1, 1'b0, 1'b0, 32'h604, 8'd1};
    tbl[11] = '{1'b0, enc(JAL,  5'd1, 5'd0), 32'h700,      1'b0, 1'b0, 1'b0, 32'h604, 8'd1};

    do_reset("reset0");
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].ins, tbl[i].pc, 1'b0, 1'b0, rdy);
      chk($sformatf("vec%0d.ready", i), rdy, 1'b1);
      chk_outs($sformatf("vec%0d", i), tbl[i].push, tbl[i].pop, tbl[i].br, 0, 0,
               tbl[i].din, tbl[i].outst, 0);
    end

    // Three branches then three correct resolutions: closes spaced every other cycle.
    do_reset("reset1");
    for (int i = 0; i < 3; i++) step(1'b1, enc(BR, 5'd0, 5'd0), 32'h800, 1'b0, 1'b0, rdy);
    chk("b2b.outstanding_open", outstanding, 8'd3);
    cv_count = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 32'h0, 32'h0, (i < 3), 1'b0, rdy);
      cv_seen[i] = ras_close_valid;
      if (ras_close_valid) cv_count++;
    end
    chk("b2b.pattern", {cv_seen[0], cv_seen[1], cv_seen[2], cv_seen[3], cv_seen[4], cv_seen[5], cv_seen[6]},
        7'b0101010);
    chk("b2b.count", cv_count, 3);
    chk("b2b.outstanding_end", outstanding, 8'd0);
    chk("b2b.err", err, 1'b0);

    // Fill the checkpoint FIFO, then free one slot with a resolution.
    do_reset("reset2");
    cv_count = 0;
    for (int i = 0; i < 129; i++) begin
      step(1'b1, enc(BR, 5'd0, 5'd0), 32'h900, 1'b0, 1'b0, rdy);
      if (rdy) cv_count++;
    end
    chk("full.accepted", cv_count, 129);
    chk("full.outstanding", outstanding, 8'd129);
    step(1'b1, enc(BR, 5'd0, 5'd0), 32'h900, 1'b0, 1'b0, rdy);
    chk("full.ready_blocked", rdy, 1'b0);
    chk("full.no_branch", ras_branch, 1'b0);
    step(1'b1, enc(BR, 5'd0, 5'd0), 32'h900, 1'b1, 1'b0, rdy);
    chk("full.ready_at_resolve", rdy, 1'b0);
    step(1'b1, enc(BR, 5'd0, 5'd0), 32'h900, 1'b0, 1'b0, rdy);
    chk("full.ready_on_close", rdy, 1'b1);
    chk("full.close_valid", ras_close_valid, 1'b1);
    chk("full.branch_with_close", ras_branch, 1'b1);
    chk("full.outstanding_net", outstanding, 8'd129);
    step(1'b1, enc(BR, 5'd0, 5'd0), 32'h900, 1'b0, 1'b0, rdy);
    chk("full.ready_refull", rdy, 1'b0);

    // Mispredict flush with a call offered in the same cycle.
    do_reset("reset3");
    for (int i = 0; i < 5; i++) step(1'b1, enc(BR, 5'd0, 5'd0), 32'hA00, 1'b0, 1'b0, rdy);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, rdy);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, rdy);
    step(1'b1, enc(JAL, 5'd1, 5'd0), 32'hB00, 1'b1, 1'b1, rdy);
    chk("flush.ready", rdy, 1'b0);
    chk_outs("flush", 0, 0, 0, 0, 1, 32'h0, 8'd0, 0);
    cv_count = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
      if (ras_close_valid || ras_close_invalid) cv_count++;
    end
    chk("flush.quiet_after", cv_count, 0);
    chk("flush.outstanding_after", outstanding, 8'd0);

    // Resolution with nothing outstanding sets a sticky error; reset clears it and drops pending.
    do_reset("reset4");
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, rdy);
    chk("err.set", err, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
    chk("err.sticky", err, 1'b1);
    chk("err.no_close", ras_close_valid, 1'b0);
    do_reset("reset5");
    cv_count = 0;
    step(1'b1, enc(BR, 5'd0, 5'd0), 32'hC00, 1'b0, 1'b0, rdy);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
      if (ras_close_valid || ras_close_invalid) cv_count++;
    end
    chk("rst.pending_dropped", cv_count, 0);
    chk("rst.outstanding_kept", outstanding, 8'd1);
    chk("rst.err_clear", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
